// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the BRAM FIFO read port, the stream reader and the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_ = 8,
  parameter int unsigned ADDR_ = 8
);
  logic             fifo_re;
  logic [ADDR_:0]   fifo_fillc;
  logic [DATA_-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [DATA_-1:0] m_data;

  // The reader side: drives the FIFO read enable and the output stream.
  modport master (
    output fifo_re,
    output m_valid,
    output m_data,
    input  fifo_fillc,
    input  fifo_dout,
    input  m_ready
  );

  // The environment side: the FIFO and the consumer.
  modport slave (
    input  fifo_re,
    input  m_valid,
    input  m_data,
    output fifo_fillc,
    output fifo_dout,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the BRAM FIFO: issues reads from the fill count, absorbs the one-cycle
// read latency and presents the words as a registered valid/ready stream through a 2-entry skid
// buffer, so full throughput survives arbitrary backpressure.
module fifo_stream_reader #(
  parameter int unsigned DATA_ = 8,
  parameter int unsigned ADDR_ = 8
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  flush,
  fifo_stream_reader_if.master  bus,
  output logic [1:0]            occ
);

  logic [1:0]       occ_q, occ_d;
  logic             pend_q;
  logic [DATA_-1:0] buf0_q, buf0_d;
  logic [DATA_-1:0] buf1_q, buf1_d;
  logic             pop;
  logic             arrive;
  logic [2:0]       inflight;
  logic             re;

  // Handshake and read-issue decision; inflight is widened so occ+pend cannot wrap.
  always_comb begin
    pop      = (occ_q != 2'd0) && bus.m_ready;
    arrive   = pend_q && !flush;
    inflight = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    re       = !flush && (bus.fifo_fillc != '0) && (inflight < 3'd2);
  end

  assign bus.fifo_re = re;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign occ         = occ_q;

  // Skid-buffer next state: buf0 is always the head word, buf1 the spare.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (arrive) begin
      if (pop && (occ_q == 2'd2)) begin
        buf0_d = buf1_q;
        buf1_d = bus.fifo_dout;
      end else if (pop) begin
        buf0_d = bus.fifo_dout;
      end else if (occ_q == 2'd0) begin
        buf0_d = bus.fifo_dout;
      end else begin
        buf1_d = bus.fifo_dout;
      end
    end else if (pop && (occ_q == 2'd2)) begin
      buf0_d = buf1_q;
    end
    // Flush wins over arrival; a pop in the flush cycle still counts as delivered.
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      occ_d = occ_q + {1'b0, arrive} - {1'b0, pop};
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= re;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

endmodule
